// File: rtl/display_pkg.sv
// display_pkg: shared constants for seven-segment display logic.
//   DIGITS    - number of multiplexed digits on the board display
//   SEG_BLANK - all-off pattern (active-low pins, so all ones)
//   SEG_TABLE - 16-entry active-low pattern table, {dp,g,f,e,d,c,b,a}, dp off
package display_pkg;

  localparam int unsigned DIGITS = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Packed so that SEG_TABLE[code] selects the pattern for hex digit 'code'.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,  // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,  // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,  // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0   // 3 2 1 0
  };

  function automatic logic [7:0] seg_encode(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/ss_driver_if.sv
// ss_driver_if: digit/brightness inputs and display pin outputs of ss_driver.
//   BCD3..BCD0     - digit codes, thousands (left) to units (right)
//   PWM            - brightness, 0 = dark
//   SegmentDrivers - active-low anode enables, bit k = digit k
//   SevenSegment   - active-low cathodes {dp,g,f,e,d,c,b,a}
// master: result logic side; slave: the display driver.
interface ss_driver_if #(
  parameter int unsigned PWM_W = 8
);
  logic [3:0]       BCD3;
  logic [3:0]       BCD2;
  logic [3:0]       BCD1;
  logic [3:0]       BCD0;
  logic [PWM_W-1:0] PWM;
  logic [7:0]       SegmentDrivers;
  logic [7:0]       SevenSegment;

  modport master (
    output BCD3, BCD2, BCD1, BCD0, PWM,
    input  SegmentDrivers, SevenSegment
  );

  modport slave (
    input  BCD3, BCD2, BCD1, BCD0, PWM,
    output SegmentDrivers, SevenSegment
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex code to active-low seven-segment pattern.
//   i_code - 4-bit hex digit
//   o_seg  - {dp,g,f,e,d,c,b,a}, active-low, dp always off
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = seg_encode(i_code);
  end

endmodule

// File: rtl/ss_driver.sv
// ss_driver: time-multiplexed 4-digit common-anode display driver with PWM dimming.
//   CLK100MHZ - system clock, rising edge
//   reset     - synchronous, active-low
//   bus       - ss_driver_if slave: BCD3..0 and PWM in, SegmentDrivers/SevenSegment out
// Each digit is shown for 2^DIGIT_LOG2 clocks; outputs are registered (1 clock latency).
module ss_driver
  import display_pkg::*;
#(
  parameter int unsigned DIGIT_LOG2 = 17,
  parameter int unsigned PWM_W      = 8
) (
  input logic         CLK100MHZ,
  input logic         reset,
  ss_driver_if.slave  bus
);

  localparam int unsigned IdxW  = $clog2(DIGITS);
  localparam int unsigned ScanW = DIGIT_LOG2 + IdxW;

  logic [ScanW-1:0] r_scan_cnt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [7:0]       r_seg_drv;
  logic [7:0]       r_seven_seg;

  logic [IdxW-1:0]  w_idx;
  logic [3:0]       w_code;
  logic             w_enable;
  logic [7:0]       w_drv;
  logic [7:0]       w_seg;

  // Digit index is the top bits of the scan counter, so the dwell is 2^DIGIT_LOG2.
  assign w_idx    = r_scan_cnt[ScanW-1 -: IdxW];
  assign w_enable = (r_pwm_cnt < bus.PWM);

  always_comb begin
    case (w_idx)
      2'd0:    w_code = bus.BCD0;
      2'd1:    w_code = bus.BCD1;
      2'd2:    w_code = bus.BCD2;
      default: w_code = bus.BCD3;
    endcase
  end

  // At most one anode low; upper nibble stays high.
  always_comb begin
    w_drv = SEG_BLANK;
    if (w_enable) begin
      w_drv[w_idx] = 1'b0;
    end
  end

  seg7_decode u_seg7_decode (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      r_scan_cnt  <= '0;
      r_pwm_cnt   <= '0;
      r_seg_drv   <= SEG_BLANK;
      r_seven_seg <= SEG_BLANK;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
      r_seg_drv   <= w_drv;
      r_seven_seg <= w_seg;
    end
  end

  assign bus.SegmentDrivers = r_seg_drv;
  assign bus.SevenSegment   = r_seven_seg;

endmodule

// File: tb/tb_ss_driver.sv
// tb_ss_driver: scoreboard bench for ss_driver with DIGIT_LOG2 = 4.
// Stimulus runs on the falling edge and pushes the expected registered outputs;
// a monitor pops and compares one entry just after every rising edge.
module tb_ss_driver;

  typedef struct packed {
    logic [7:0] drv;
    logic [7:0] seg;
    logic       cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t q[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   low_cnt  = 0;
  logic count_en = 1'b0;
  int   m_scan   = 0;
  int   m_pwm    = 0;

  always #5 clk = ~clk;

  ss_driver_if #(.PWM_W(8)) bus ();

  ss_driver #(
    .DIGIT_LOG2 (4),
    .PWM_W      (8)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .bus       (bus)
  );

  function automatic logic [7:0] ref_seg(input logic [3:0] c);
    case (c)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs registered at the next rising edge, then wait one cycle.
  task automatic step();
    exp_t       e;
    int         idx;
    logic [3:0] code;
    if (!rst_n) begin
      e.drv  = 8'hFF;
      e.seg  = 8'hFF;
      m_scan = 0;
      m_pwm  = 0;
    end else begin
      idx = (m_scan >> 4) % 4;
      case (idx)
        0:       code = bus.BCD0;
        1:       code = bus.BCD1;
        2:       code = bus.BCD2;
        default: code = bus.BCD3;
      endcase
      e.drv = 8'hFF;
      if (m_pwm < int'(bus.PWM)) e.drv[idx] = 1'b0;
      e.seg  = ref_seg(code);
      m_scan = (m_scan + 1) % 64;
      m_pwm  = (m_pwm + 1) % 256;
    end
    e.cnt = count_en;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("anodes", {24'd0, bus.SegmentDrivers}, {24'd0, mon_e.drv});
      check("cathodes", {24'd0, bus.SevenSegment}, {24'd0, mon_e.seg});
      check("fixed_high", {30'd0, &bus.SegmentDrivers[7:4], bus.SevenSegment[7]}, 32'd3);
      check("one_anode", {31'd0, ($countones(~bus.SegmentDrivers[3:0]) <= 1)}, 32'd1);
      if (mon_e.cnt && (bus.SegmentDrivers[3:0] != 4'hF)) low_cnt++;
    end
  end

  initial begin
    bus.BCD3 = 4'd1;
    bus.BCD2 = 4'd2;
    bus.BCD1 = 4'd3;
    bus.BCD0 = 4'd4;
    bus.PWM  = 8'd255;
    @(negedge clk);

    // Reset held for 3 clocks, then normal scan through all digits and back.
    rst_n = 1'b0;
    steps(3);
    rst_n = 1'b1;
    steps(80);

    // Dark display.
    bus.PWM = 8'd0;
    steps(512);

    // Half brightness: any 256 consecutive cycles contain 128 lit ones.
    bus.PWM = 8'd128;
    step();
    count_en = 1'b1;
    steps(256);
    count_en = 1'b0;
    steps(2);
    check("pwm128_lit_cycles", low_cnt, 128);

    // Decode sweep over BCD0, one full scan period per code.
    bus.PWM = 8'd255;
    for (int i = 0; i < 64 && m_scan != 0; i++) step();
    for (int v = 0; v < 16; v++) begin
      bus.BCD0 = 4'(v);
      steps(64);
    end
    bus.BCD0 = 4'd4;

    // Reset in the middle of digit 2.
    for (int i = 0; i < 64 && m_scan != 37; i++) step();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    steps(70);

    // Live change of BCD1 while digit 1 is showing.
    for (int i = 0; i < 64 && m_scan != 20; i++) step();
    steps(3);
    bus.BCD1 = 4'd9;
    steps(6);

    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
